// File: rtl/deff_pkg.sv
// Shared limits and types for the dual-edge delay line.
// The optional sample counter is enabled with the DEFF_SAMPLE_CNT_EN macro.
package deff_pkg;

   localparam int WIDTH_MIN     = 1;
   localparam int WIDTH_MAX     = 32;
   localparam int DEPTH_MIN     = 1;
   localparam int DEPTH_MAX     = 16;
   localparam int CNT_W_DEFAULT = 16;

   // One sample as it travels down the line; data is sized for the widest build.
   typedef struct packed {
      logic                 valid;
      logic [WIDTH_MAX-1:0] data;
   } sample_t;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

   function automatic bit depth_ok(input int d);
      return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
   endfunction

endpackage

// File: rtl/deff_cell.sv
// One dual-edge register stage: a rising-edge half and a falling-edge half whose
// XOR is the stage output, so the stage takes d on every enabled clk edge.
module deff_cell
   import deff_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] pos_half;
   logic [W-1:0] neg_half;

   // NOTE: state uses non-blocking assignments so both halves read the other
   // half's pre-edge value; the async clear makes q=0 without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_half <= '0;
      end else if (en) begin
         pos_half <= d ^ neg_half;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_half <= '0;
      end else if (en) begin
         neg_half <= d ^ pos_half;
      end
   end

   assign q = pos_half ^ neg_half;

endmodule

// File: rtl/deff_delay_line.sv
// DEPTH-stage dual-edge delay line carrying {valid, data} on both clk edges.
// Define DEFF_SAMPLE_CNT_EN to add the valid-output counter and sample_cnt port.
module deff_delay_line
   import deff_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid
`ifdef DEFF_SAMPLE_CNT_EN
   ,
   output logic [CNT_W-1:0] sample_cnt
`endif
);

   localparam int SW = WIDTH + 1;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("deff_delay_line: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end
   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("deff_delay_line: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
   end

   logic [SW-1:0] stage_in  [DEPTH];
   logic [SW-1:0] stage_out [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign stage_in[k] = {din_valid, din};
      end else begin : g_link
         assign stage_in[k] = stage_out[k-1];
      end

      deff_cell #(
         .W (SW)
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .d     (stage_in[k]),
         .q     (stage_out[k])
      );
   end

   // The last stage output goes straight out; an extra register would add latency.
   assign dout       = stage_out[DEPTH-1][WIDTH-1:0];
   assign dout_valid = stage_out[DEPTH-1][WIDTH];

`ifdef DEFF_SAMPLE_CNT_EN
   logic             next_last_valid;
   logic [CNT_W-1:0] pos_cnt;
   logic [CNT_W-1:0] neg_cnt;

   // Counts on the edge that loads a valid sample into the last stage.
   assign next_last_valid = stage_in[DEPTH-1][WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_cnt <= '0;
      end else if (en && next_last_valid) begin
         pos_cnt <= pos_cnt + 1'b1;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_cnt <= '0;
      end else if (en && next_last_valid) begin
         neg_cnt <= neg_cnt + 1'b1;
      end
   end

   assign sample_cnt = pos_cnt + neg_cnt;
`endif

endmodule

// File: tb/tb_deff_delay_line.sv
// Scoreboard bench for deff_delay_line: DEPTH=4/CNT_W=16 and DEPTH=1/CNT_W=4 instances.
// Sample counter checks are active only when DEFF_SAMPLE_CNT_EN is defined.
module tb_deff_delay_line;
   import deff_pkg::*;

   localparam int D4 = 4;
   localparam int D1 = 1;

   typedef struct {
      logic [7:0]  d4;
      logic        v4;
      bit          care4;
      logic [15:0] c4;
      logic [7:0]  d1;
      logic        v1;
      bit          care1;
      logic [3:0]  c1;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [7:0]  din;
   logic        din_valid;
   logic [7:0]  dout4;
   logic        dv4;
   logic [7:0]  dout1;
   logic        dv1;
`ifdef DEFF_SAMPLE_CNT_EN
   logic [15:0] cnt4;
   logic [3:0]  cnt1;
`endif

   int   checks  = 0;
   int   errors  = 0;
   bit   running = 0;
   exp_t exp_q [$];

   sample_t hist4 [$];
   sample_t hist1 [$];
   int      mcnt4 = 0;
   int      mcnt1 = 0;

   deff_delay_line #(.WIDTH(8), .DEPTH(D4), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout4),
      .dout_valid (dv4)
`ifdef DEFF_SAMPLE_CNT_EN
      ,
      .sample_cnt (cnt4)
`endif
   );

   deff_delay_line #(.WIDTH(8), .DEPTH(D1), .CNT_W(4)) u_d1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout1),
      .dout_valid (dv1)
`ifdef DEFF_SAMPLE_CNT_EN
      ,
      .sample_cnt (cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each line output is the sample captured DEPTH-1 enabled edges ago.
   function automatic exp_t model_edge(input bit e, input sample_t s);
      exp_t x;
      if (e) begin
         hist4.push_back(s);
         if (hist4.size() > D4) void'(hist4.pop_front());
         hist1.push_back(s);
         if (hist1.size() > D1) void'(hist1.pop_front());
      end
      if (hist4.size() == D4) begin
         x.v4 = hist4[0].valid; x.d4 = hist4[0].data[7:0]; x.care4 = hist4[0].valid;
      end else begin
         x.v4 = 1'b0; x.d4 = 8'h00; x.care4 = 1'b1;
      end
      if (hist1.size() == D1) begin
         x.v1 = hist1[0].valid; x.d1 = hist1[0].data[7:0]; x.care1 = hist1[0].valid;
      end else begin
         x.v1 = 1'b0; x.d1 = 8'h00; x.care1 = 1'b1;
      end
      if (e && x.v4) mcnt4++;
      if (e && x.v1) mcnt1++;
      x.c4 = 16'(mcnt4 % 65536);
      x.c1 = 4'(mcnt1 % 16);
      return x;
   endfunction

   function automatic void model_reset();
      hist4.delete();
      hist1.delete();
      mcnt4 = 0;
      mcnt1 = 0;
   endfunction

   // Drives one edge's inputs, predicts the post-edge outputs, then waits for the edge.
   task automatic step(input bit e, input bit v, input logic [7:0] d);
      exp_t    x;
      sample_t s;
      en = e; din_valid = v; din = d;
      if (rst_n) begin
         s.valid = v;
         s.data  = WIDTH_MAX'(d);
         x = model_edge(e, s);
      end else begin
         x.d4 = 8'h00; x.v4 = 1'b0; x.care4 = 1'b1; x.c4 = 16'h0;
         x.d1 = 8'h00; x.v1 = 1'b0; x.care1 = 1'b1; x.c1 = 4'h0;
      end
      exp_q.push_back(x);
      @(posedge clk or negedge clk);
      #3;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_dout4"}, 32'(dout4), 32'h0);
      check({tag, "_dv4"},   32'(dv4),   32'h0);
      check({tag, "_dout1"}, 32'(dout1), 32'h0);
      check({tag, "_dv1"},   32'(dv1),   32'h0);
`ifdef DEFF_SAMPLE_CNT_EN
      check({tag, "_cnt4"},  32'(cnt4),  32'h0);
      check({tag, "_cnt1"},  32'(cnt1),  32'h0);
`endif
   endtask

   // Called mid half-cycle: outputs must clear without any clock edge.
   task automatic reset_mid(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero(tag);
      step(1'b1, 1'b1, 8'hEE);
      step(1'b1, 1'b1, 8'hDD);
      rst_n = 1'b1;
   endtask

   // Monitor: compares one scoreboard entry per clk edge, away from the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk or negedge clk);
         #2;
         if (running) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               x = exp_q.pop_front();
               check("dv4", 32'(dv4), 32'(x.v4));
               if (x.care4) check("dout4", 32'(dout4), 32'(x.d4));
               check("dv1", 32'(dv1), 32'(x.v1));
               if (x.care1) check("dout1", 32'(dout1), 32'(x.d1));
`ifdef DEFF_SAMPLE_CNT_EN
               check("cnt4", 32'(cnt4), 32'(x.c4));
               check("cnt1", 32'(cnt1), 32'(x.c1));
`endif
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; din = 8'h00; din_valid = 1'b0;
      #1;
      check_zero("reset");
      #2;
      rst_n   = 1'b1;
      running = 1'b1;

      // Single valid 0xA5 on the first rising edge, then invalid filler.
      step(1'b1, 1'b1, 8'hA5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00);

      // Full ramp then drain.
      reset_mid("rst_a");
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
`ifdef DEFF_SAMPLE_CNT_EN
      check("ramp_cnt16", 32'(cnt4), 32'd16);
`endif

      // Ramp with a three-edge stall in the middle.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h40 + i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF);
      for (int i = 6; i < 12; i++) step(1'b1, 1'b1, 8'(8'h40 + i));

      // Random traffic with sporadic stalls and invalid samples.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom));

      // Reset while samples are in flight; only new data may appear afterwards.
      reset_mid("rst_b");
      for (int i = 0; i < 100; i++)
         step($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, 8'($urandom));

      // Seventeen valid samples from a clean start: 4-bit counter wraps 15->0->1.
      reset_mid("rst_c");
      for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
`ifdef DEFF_SAMPLE_CNT_EN
      check("wrap_cnt1", 32'(cnt1), 32'd1);
`endif
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);

      running = 1'b0;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/deff_delay_line.md
DEFF_DELAY_LINE -- requirements
Module: deff_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per sample (range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of dual-edge stages (range 1..16).
REQ-003 The block SHALL have parameter CNT_W, default 16, sample-counter width.
REQ-004 The block SHALL have port clk, input, 1, single clock; both edges active.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1, advance enable, sampled on every clk edge.
REQ-007 The block SHALL have port din, input, WIDTH, sample data.
REQ-008 The block SHALL have port din_valid, input, 1, din qualifier.
REQ-009 The block SHALL have port dout, output, WIDTH, data from the last stage.
REQ-010 The block SHALL have port dout_valid, output, 1, valid flag from the last stage.
REQ-011 The block SHALL have port sample_cnt, output, CNT_W, count of valid output samples; present only with DEFF_SAMPLE_CNT_EN.

Function
REQ-012 Each stage SHALL be a dual-edge register: a posedge half and a negedge half, with the output equal to their XOR; each half loads (next XOR other-half) so that the stage takes next on every edge.
REQ-013 Stage 0 SHALL take {din_valid, din} and stage k SHALL take stage k-1, on every clk edge (rising or falling) where en=1.
REQ-014 With en=0 at an edge, every stage and the counter SHALL hold; no partial advance.
REQ-015 Latency: a sample captured at edge e SHALL appear on dout/dout_valid after edge e+DEPTH-1 (DEPTH half-cycles, counted in enabled edges).
REQ-016 dout and dout_valid SHALL be combinational XOR of last-stage halves only; no extra register.
REQ-017 Invalid samples (din_valid=0) SHALL propagate with dout_valid=0; dout content is then don't-care but deterministic.
REQ-018 sample_cnt SHALL increment by 1 on each enabled edge where the new last-stage valid is 1, wrapping from 2^CNT_W-1 to 0 without flag.
REQ-019 The counter SHALL be built as a posedge count plus a negedge count; sample_cnt equals their sum modulo 2^CNT_W.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear both halves of every stage and both counter halves; dout=0, dout_valid=0, sample_cnt=0 while asserted.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight samples; none reappears after release.
REQ-022 After rst_n rises, the first edge of either polarity with en=1 SHALL be the first capture edge.

Configuration
REQ-023 Macro DEFF_SAMPLE_CNT_EN defined: the counter and sample_cnt port SHALL exist per REQ-018/019.
REQ-024 Macro DEFF_SAMPLE_CNT_EN undefined: no counter logic and no sample_cnt port; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package deff_pkg SHALL hold the WIDTH/DEPTH limits, default CNT_W, and a sample typedef {valid, data}.
REQ-026 One sub-module deff_cell (parametrised width, async active-low reset, enable) SHALL implement one dual-edge stage; deff_delay_line instantiates DEPTH of them in a generate loop.
REQ-027 Illegal WIDTH/DEPTH SHALL stop elaboration with an error.

Verification
REQ-028 WIDTH=8, DEPTH=4, en=1, din=0xA5 valid on rising edge 0, then 0x00 invalid -> dout=0xA5, dout_valid=1 exactly after falling edge 1 (edge 3), for one half-cycle.
REQ-029 Ramp 0x00..0x0F valid, one per edge -> dout shows the same ramp, one value per half-cycle, 4 edges late; sample_cnt=16 after the last one exits.
REQ-030 Ramp running, en=0 for 3 edges, then en=1 -> dout frozen for those 3 edges, sequence resumes with no lost or duplicated value.
REQ-031 Ramp running, rst_n low mid-half-cycle -> dout=0, dout_valid=0, sample_cnt=0 immediately; after release only new inputs appear.
REQ-032 CNT_W=4, 17 valid samples -> sample_cnt wraps 15->0->1.
REQ-033 DEPTH=1 and build without DEFF_SAMPLE_CNT_EN -> dout follows din on the same capture edge; no sample_cnt port present.
